// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC and issues one fetch at a time.
// It hands each fetched word to the decoder, and a redirect squashes any stale fetch.
module ifu #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  typedef enum logic [1:0] {
    ST_REQ,   // request for pc offered to memory
    ST_WAIT,  // request accepted, response pending
    ST_HOLD,  // instruction buffered for the decoder
    ST_DROP   // pending response is stale and will be discarded
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] target;
  logic [31:0]     inst_buf_q, inst_buf_d;

  assign target = {redirect_pc[XLEN-1:2], 2'b00};

  // NOTE: every variable is given its hold value first, so no branch can leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_buf_d = inst_buf_q;
    unique case (state_q)
      ST_REQ: begin
        if (redirect_valid) begin
          pc_d = target;
          if (imem_req_ready) state_d = ST_DROP;
        end else if (imem_req_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          pc_d    = target;
          state_d = imem_resp_valid ? ST_REQ : ST_DROP;
        end else if (imem_resp_valid) begin
          inst_buf_d = imem_resp_data;
          state_d    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          pc_d    = target;
          state_d = ST_REQ;
        end else if (inst_ready) begin
          pc_d    = pc_q + XLEN'(4);
          state_d = ST_REQ;
        end
      end
      ST_DROP: begin
        // The newest redirect target wins while the stale response is still in flight.
        if (redirect_valid) pc_d = target;
        if (imem_resp_valid) state_d = ST_REQ;
      end
      default: state_d = ST_REQ;
    endcase
  end

  // NOTE: registers use non-blocking assignments, so every flop samples the pre-edge values at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_REQ;
      pc_q       <= RESET_PC;
      inst_buf_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_buf_q <= inst_buf_d;
    end
  end

  assign imem_req_valid = (state_q == ST_REQ);
  assign imem_req_addr  = pc_q;
  // A same-cycle redirect kills the held instruction before the decoder can take it.
  assign inst_valid     = (state_q == ST_HOLD) & ~redirect_valid;
  assign inst           = inst_buf_q;
  assign inst_pc        = pc_q;

endmodule
